shape_processor_ctrl_array: RTL and testbench
=============================================

Name: shape_processor_ctrl_array

Overview:
- Multi-channel successor to the single shape processor CTRL SFR.
- Holds NUM_CH independent CTRL registers and filters bus writes using KEEP_SHAPE/KEEP_OPERATION semantics, field-legality rules and shape/operation combination rules.
- Each accepted write launches a per-channel job to the downstream compute engine through a round-robin arbitrated valid/ready start interface.
- Sits between the SFR bus adapter and the shape compute engines.

Parameters:
- NUM_CH, 4, number of channels (2..16).
- CH_W, $clog2(NUM_CH), channel index width (derived; do not override).
- ERR_CNT_W, 8, width of the saturating rejected-write counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept; combinational, equals !pending[wr_ch].
- wr_ch  in  CH_W  target channel.
- wr_data  in  32  CTRL image: SHAPE=[17:16], OPERATION=[4:0], all other bits reserved.
- wr_done  out  1  one-cycle pulse, the cycle after a write handshake.
- wr_err  out  1  valid with wr_done; 1 means the write was rejected.
- rd_en  in  1  read request.
- rd_ch  in  CH_W  read channel.
- rd_valid  out  1  pulse, the cycle after rd_en.
- rd_data  out  32  {14'b0, SHAPE, 11'b0, OPERATION}; 0 when rd_valid=0.
- start_valid  out  1  job launch request.
- start_ready  in  1  engine accepts job.
- start_ch  out  CH_W  channel of the launched job.
- start_shape  out  2  shape snapshot.
- start_op  out  5  operation snapshot.
- err_cnt  out  ERR_CNT_W  saturating count of rejected writes.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - every channel: SHAPE=RECTANGLE(01), OPERATION=PERIMETER(00000);
  - pending=0, rr pointer=NUM_CH-1;
  - all outputs 0 except wr_ready, which follows pending (=1).
- Reset mid-operation aborts any in-flight start immediately. No job is retained.
- Write resolution, on handshake wr_valid&&wr_ready:
  - Step 1: new_shape = (wr_data[17:16]==00) ? current : wr_data[17:16].
  - Step 2: new_op = (wr_data[4:0]==11111) ? current : wr_data[4:0].
  - Reject if the raw SHAPE field is 11, or the raw OP field is not in {00000,00001,01000,10000,10001,11111}.
  - Otherwise reject if the resolved pair is illegal:
    - PERIMETER and AREA are legal with any shape;
    - IS_SQUARE needs RECTANGLE;
    - IS_EQUILATERAL and IS_ISOSCELES need TRIANGLE.
  - Reserved bits are ignored.
  - A rejected write leaves the register and pending unchanged. wr_err=1 next cycle; err_cnt increments, saturating at all-ones.
  - An accepted write updates the register and sets pending[wr_ch]. wr_err=0. A write of all-KEEP (resolves to the current values) is accepted and relaunches the job.
- wr_ready is low while pending[wr_ch]=1. A stalled master holds wr_valid and its fields stable.
- Start path:
  - Output registers load when (!start_valid || start_ready) and any pending bit is set.
  - Round-robin grant searches upward from rr+1, wrapping at NUM_CH-1 -> 0.
  - On load: snapshot the channel's register into start_shape/op, set start_ch, set rr=granted, clear pending[granted], start_valid=1.
  - If no pending bit is set and start_ready=1: start_valid drops to 0.
  - Fields stay stable while start_valid && !start_ready.
  - Back-to-back jobs are allowed (one per cycle under continuous ready).
- Latency: write accepted at edge t -> start_valid high after edge t+1 at the earliest. A channel becomes writable again the cycle after its job is loaded, even if that job is still awaiting start_ready; the snapshot is unaffected.
- Simultaneous events:
  - err_clr and a reject in the same cycle -> err_cnt=0 (clear wins).
  - A write to channel X and a read of X in the same cycle -> rd_data returns the pre-write value.
  - A new set and the arbiter load never target the same channel in one cycle (wr_ready gate).

Test Plan:
- After reset: read ch0 -> rd_data=0x0001_0000. Write ch0 0x0002_0010 -> wr_err=0, rd=0x0002_0010, start: ch0/10/10000 after one cycle.
- Ch1 (RECTANGLE) written 0x0000_0010 (KEEP shape, IS_EQUILATERAL) -> wr_err=1, err_cnt=1, no start. Then 0x0003_0000 and 0x0000_0005 -> both rejected, err_cnt=3.
- Writes to ch0..ch3 on consecutive cycles with start_ready held 0 for 5 cycles, then 1 -> starts issue in order 0,1,2,3. A second write to ch2 while pending -> wr_ready=0 until ch2 is loaded.
- Write 0x0000_001F to ch3 (all KEEP) -> accepted, start with ch3 values 01/00000.
- err_cnt at 0xFF plus a reject -> stays 0xFF. err_clr with a simultaneous reject -> 0.
- rst_n pulsed low while start_valid=1 awaits ready -> start_valid=0 immediately, registers at reset values, no start after release.

Source files
------------

// File: rtl/shape_processor_ctrl_array_if.sv
// Bus bundle for the shape processor CTRL array: write/read SFR access, the job-start
// handshake toward the compute engines and the rejected-write counter.
interface shape_processor_ctrl_array_if #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int ERR_CNT_W = 8
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [CH_W-1:0]      wr_ch;
    logic [31:0]          wr_data;
    logic                 wr_done;
    logic                 wr_err;
    logic                 rd_en;
    logic [CH_W-1:0]      rd_ch;
    logic                 rd_valid;
    logic [31:0]          rd_data;
    logic                 start_valid;
    logic                 start_ready;
    logic [CH_W-1:0]      start_ch;
    logic [1:0]           start_shape;
    logic [4:0]           start_op;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_clr;

    modport master (
        output wr_valid, wr_ch, wr_data, rd_en, rd_ch, start_ready, err_clr,
        input  wr_ready, wr_done, wr_err, rd_valid, rd_data,
               start_valid, start_ch, start_shape, start_op, err_cnt
    );

    modport slave (
        input  wr_valid, wr_ch, wr_data, rd_en, rd_ch, start_ready, err_clr,
        output wr_ready, wr_done, wr_err, rd_valid, rd_data,
               start_valid, start_ch, start_shape, start_op, err_cnt
    );
endinterface

// File: rtl/shape_processor_ctrl_array.sv
// Array of shape processor CTRL registers: filters bus writes against the shape/operation
// rules and launches one job per accepted write through a round-robin start port.
module shape_processor_ctrl_array #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int ERR_CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    shape_processor_ctrl_array_if.slave bus
);
    localparam logic [1:0] SHAPE_KEEP = 2'b00;
    localparam logic [1:0] SHAPE_RECT = 2'b01;
    localparam logic [1:0] SHAPE_TRI  = 2'b10;
    localparam logic [1:0] SHAPE_BAD  = 2'b11;
    localparam logic [4:0] OP_PERIM   = 5'b00000;
    localparam logic [4:0] OP_AREA    = 5'b00001;
    localparam logic [4:0] OP_SQUARE  = 5'b01000;
    localparam logic [4:0] OP_EQUI    = 5'b10000;
    localparam logic [4:0] OP_ISO     = 5'b10001;
    localparam logic [4:0] OP_KEEP    = 5'b11111;

    logic [1:0]        shape_q [NUM_CH];
    logic [4:0]        op_q    [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   rr;

    logic [1:0]        raw_shape, new_shape;
    logic [4:0]        raw_op, new_op;
    logic              raw_bad, pair_bad;
    logic              wr_fire, wr_reject, wr_accept;
    logic              found, load;
    logic [CH_W-1:0]   grant, idx;
    logic [NUM_CH-1:0] set_mask, clr_mask;
    logic              unused_reserved;

    assign bus.wr_ready    = !pending[bus.wr_ch];
    assign unused_reserved = ^{bus.wr_data[31:18], bus.wr_data[15:5]};

    // KEEP codes resolve to the channel's current value before the combination rules apply.
    always_comb begin
        raw_shape = bus.wr_data[17:16];
        raw_op    = bus.wr_data[4:0];
        new_shape = (raw_shape == SHAPE_KEEP) ? shape_q[bus.wr_ch] : raw_shape;
        new_op    = (raw_op == OP_KEEP) ? op_q[bus.wr_ch] : raw_op;
        raw_bad   = (raw_shape == SHAPE_BAD) ||
                    !(raw_op inside {OP_PERIM, OP_AREA, OP_SQUARE, OP_EQUI, OP_ISO, OP_KEEP});
        case (new_op)
            OP_SQUARE:       pair_bad = (new_shape != SHAPE_RECT);
            OP_EQUI, OP_ISO: pair_bad = (new_shape != SHAPE_TRI);
            default:         pair_bad = 1'b0;
        endcase
        wr_fire   = bus.wr_valid && !pending[bus.wr_ch];
        wr_reject = raw_bad || pair_bad;
        wr_accept = wr_fire && !wr_reject;
    end

    always_comb begin
        grant = rr;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(rr) + i) % NUM_CH);
            if (!found && pending[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        load     = (!bus.start_valid || bus.start_ready) && found;
        set_mask = '0;
        clr_mask = '0;
        if (wr_accept) set_mask[bus.wr_ch] = 1'b1;
        if (load)      clr_mask[grant]     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shape_q[c] <= SHAPE_RECT;
                op_q[c]    <= OP_PERIM;
            end
            pending <= '0;
        end else begin
            if (wr_accept) begin
                shape_q[bus.wr_ch] <= new_shape;
                op_q[bus.wr_ch]    <= new_op;
            end
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // The snapshot is taken at load, so a later rewrite of the channel cannot disturb a held job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.start_valid <= 1'b0;
            bus.start_ch    <= '0;
            bus.start_shape <= '0;
            bus.start_op    <= '0;
            rr              <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            bus.start_valid <= 1'b1;
            bus.start_ch    <= grant;
            bus.start_shape <= shape_q[grant];
            bus.start_op    <= op_q[grant];
            rr              <= grant;
        end else if (bus.start_ready) begin
            bus.start_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_done  <= 1'b0;
            bus.wr_err   <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.err_cnt  <= '0;
        end else begin
            bus.wr_done  <= wr_fire;
            bus.wr_err   <= wr_fire && wr_reject;
            bus.rd_valid <= bus.rd_en;
            bus.rd_data  <= bus.rd_en ? {14'b0, shape_q[bus.rd_ch], 11'b0, op_q[bus.rd_ch]} : '0;
            if (bus.err_clr)
                bus.err_cnt <= '0;
            else if (wr_fire && wr_reject && !(&bus.err_cnt))
                bus.err_cnt <= bus.err_cnt + ERR_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_shape_processor_ctrl_array.sv
// Self-checking bench for shape_processor_ctrl_array: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the CTRL array.
module tb_shape_processor_ctrl_array;
    localparam int NUM_CH    = 4;
    localparam int CH_W      = 2;
    localparam int ERR_CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total;
    int   bad;

    always #5 clk = ~clk;

    shape_processor_ctrl_array_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

    shape_processor_ctrl_array #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural model state
    logic [1:0]        m_shape [NUM_CH];
    logic [4:0]        m_op    [NUM_CH];
    bit   [NUM_CH-1:0] m_pend;
    int                m_rr;
    bit                m_sv;
    logic [CH_W-1:0]   m_sch;
    logic [1:0]        m_sshape;
    logic [4:0]        m_sop;
    bit                m_done, m_err, m_rv;
    logic [31:0]       m_rdata;
    int                m_cnt;

    function automatic bit op_known(logic [4:0] o);
        return o inside {5'd0, 5'd1, 5'd8, 5'd16, 5'd17, 5'd31};
    endfunction

    // Shape an operation requires: 0 means any shape is fine.
    function automatic logic [1:0] shape_needed(logic [4:0] o);
        if (o == 5'd8) return 2'b01;
        if (o == 5'd16 || o == 5'd17) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int c, g;
        bit fire, rej;
        logic [1:0] rs, ns;
        logic [4:0] ro, no;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_shape[i] = 2'b01;
                m_op[i]    = 5'b00000;
            end
            m_pend = '0; m_rr = NUM_CH - 1; m_sv = 0; m_sch = '0; m_sshape = '0; m_sop = '0;
            m_done = 0; m_err = 0; m_rv = 0; m_rdata = '0; m_cnt = 0;
        end else begin
            c    = int'(bus.wr_ch);
            fire = bus.wr_valid && !m_pend[c];
            rs   = bus.wr_data[17:16];
            ro   = bus.wr_data[4:0];
            ns   = (rs == 2'b00) ? m_shape[c] : rs;
            no   = (ro == 5'd31) ? m_op[c] : ro;
            rej  = (rs == 2'b11) || !op_known(ro) ||
                   (shape_needed(no) != 2'b00 && shape_needed(no) != ns);
            m_rv    = bus.rd_en;
            m_rdata = bus.rd_en ? {14'b0, m_shape[bus.rd_ch], 11'b0, m_op[bus.rd_ch]} : 32'h0;
            if (!m_sv || bus.start_ready) begin
                g = -1;
                for (int k = 1; k <= NUM_CH; k++)
                    if (g < 0 && m_pend[(m_rr + k) % NUM_CH]) g = (m_rr + k) % NUM_CH;
                if (g >= 0) begin
                    m_sv = 1; m_sch = CH_W'(g); m_sshape = m_shape[g]; m_sop = m_op[g];
                    m_rr = g; m_pend[g] = 0;
                end else if (bus.start_ready) begin
                    m_sv = 0;
                end
            end
            if (fire && !rej) begin
                m_shape[c] = ns; m_op[c] = no; m_pend[c] = 1;
            end
            m_done = fire;
            m_err  = fire && rej;
            if (bus.err_clr) m_cnt = 0;
            else if (fire && rej && m_cnt < 255) m_cnt = m_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.wr_valid = 0; bus.wr_ch = '0; bus.wr_data = '0;
        bus.rd_en = 0; bus.rd_ch = '0; bus.err_clr = 0;
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] d;
        int p;
        logic [4:0] ops [6] = '{5'd0, 5'd1, 5'd8, 5'd16, 5'd17, 5'd31};
        d = $urandom();
        d[17:16] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        p = $urandom_range(0, 7);
        d[4:0] = (p < 6) ? ops[p] : 5'($urandom());
        return d;
    endfunction

    task automatic test_reset();
        drive_idle();
        bus.start_ready = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_start_valid got=%b want=0", bus.start_valid); end
        total++; if (bus.err_cnt !== 8'h00) begin bad++; $display("[TB] FAIL reset_err_cnt got=%h want=00", bus.err_cnt); end
        total++; if (bus.wr_done !== 1'b0 || bus.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulses got=%b%b want=00", bus.wr_done, bus.rd_valid); end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bus.wr_ch = CH_W'(ch);
            #1;
            total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_wr_ready ch%0d got=%b want=1", ch, bus.wr_ready); end
        end
        bus.wr_ch = '0;
        @(negedge clk);
        bus.rd_en = 1; bus.rd_ch = 0;
        tick();
        bus.rd_en = 0;
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("[TB] FAIL reset_rd_valid got=%b want=1", bus.rd_valid); end
        total++; if (bus.rd_data !== 32'h0001_0000) begin bad++; $display("[TB] FAIL reset_rd_data got=%h want=00010000", bus.rd_data); end
    endtask

    task automatic test_keep();
        bus.start_ready = 1;
        bus.wr_valid = 1; bus.wr_ch = 3; bus.wr_data = 32'h0000_001F;
        tick();
        bus.wr_valid = 0;
        total++; if (bus.wr_done !== 1'b1 || bus.wr_err !== 1'b0) begin bad++; $display("[TB] FAIL keep_resp got done=%b err=%b want 1/0", bus.wr_done, bus.wr_err); end
        total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL keep_latency got=%b want=0", bus.start_valid); end
        tick();
        total++; if (bus.start_valid !== 1'b1 || bus.start_ch !== 2'd3 || bus.start_shape !== 2'b01 || bus.start_op !== 5'b00000)
            begin bad++; $display("[TB] FAIL keep_start got v=%b ch=%0d sh=%b op=%b want 1/3/01/00000", bus.start_valid, bus.start_ch, bus.start_shape, bus.start_op); end
        tick();
        total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL keep_drop got=%b want=0", bus.start_valid); end
    endtask

    task automatic test_basic_write();
        bus.start_ready = 1;
        bus.wr_valid = 1; bus.wr_ch = 0; bus.wr_data = 32'h0002_0010;
        bus.rd_en = 1; bus.rd_ch = 0;
        #1;
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_wr_ready got=%b want=1", bus.wr_ready); end
        tick();
        bus.wr_valid = 0;
        total++; if (bus.wr_done !== 1'b1 || bus.wr_err !== 1'b0) begin bad++; $display("[TB] FAIL basic_resp got done=%b err=%b want 1/0", bus.wr_done, bus.wr_err); end
        total++; if (bus.rd_data !== 32'h0001_0000) begin bad++; $display("[TB] FAIL basic_pre_write_read got=%h want=00010000", bus.rd_data); end
        total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_latency got=%b want=0", bus.start_valid); end
        tick();
        bus.rd_en = 0;
        total++; if (bus.rd_data !== 32'h0002_0010) begin bad++; $display("[TB] FAIL basic_read got=%h want=00020010", bus.rd_data); end
        total++; if (bus.start_valid !== 1'b1 || bus.start_ch !== 2'd0 || bus.start_shape !== 2'b10 || bus.start_op !== 5'b10000)
            begin bad++; $display("[TB] FAIL basic_start got v=%b ch=%0d sh=%b op=%b want 1/0/10/10000", bus.start_valid, bus.start_ch, bus.start_shape, bus.start_op); end
        tick();
        total++; if (bus.start_valid !== 1'b0 || bus.wr_done !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0)
            begin bad++; $display("[TB] FAIL basic_idle got v=%b done=%b rv=%b rd=%h want all 0", bus.start_valid, bus.wr_done, bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_reject();
        logic [31:0] data [3] = '{32'h0000_0010, 32'h0003_0000, 32'h0000_0005};
        bus.start_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1; bus.wr_ch = 1; bus.wr_data = data[i];
            tick();
            total++; if (bus.wr_done !== 1'b1 || bus.wr_err !== 1'b1) begin bad++; $display("[TB] FAIL reject_resp%0d got done=%b err=%b want 1/1", i, bus.wr_done, bus.wr_err); end
            total++; if (bus.err_cnt !== ERR_CNT_W'(i + 1)) begin bad++; $display("[TB] FAIL reject_cnt%0d got=%0d want=%0d", i, bus.err_cnt, i + 1); end
            total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL reject_nostart%0d got=%b want=0", i, bus.start_valid); end
        end
        bus.wr_valid = 0;
        bus.rd_en = 1; bus.rd_ch = 1;
        tick();
        bus.rd_en = 0;
        total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL reject_late_start got=%b want=0", bus.start_valid); end
        total++; if (bus.rd_data !== 32'h0001_0000) begin bad++; $display("[TB] FAIL reject_reg got=%h want=00010000", bus.rd_data); end
    endtask

    task automatic test_order();
        logic [31:0] wdata [4] = '{32'h0001_0008, 32'h0002_0011, 32'h0000_0001, 32'h0002_0000};
        int exp_ch [5] = '{0, 1, 2, 3, 2};
        logic [1:0] exp_sh [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
        logic [4:0] exp_op [5] = '{5'd8, 5'd17, 5'd1, 5'd0, 5'd16};
        logic [CH_W-1:0] rec_ch [5];
        logic [1:0] rec_sh [5];
        logic [4:0] rec_op [5];
        int got, cyc;
        bit drop;
        bus.start_ready = 0;
        for (int ch = 0; ch < 4; ch++) begin
            bus.wr_valid = 1; bus.wr_ch = CH_W'(ch); bus.wr_data = wdata[ch];
            #1;
            total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL order_wr_ready ch%0d got=%b want=1", ch, bus.wr_ready); end
            tick();
        end
        bus.wr_valid = 1; bus.wr_ch = 2; bus.wr_data = 32'h0002_0010;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL order_blocked%0d got=%b want=0", i, bus.wr_ready); end
            total++; if (bus.start_valid !== 1'b1 || bus.start_ch !== 2'd0) begin bad++; $display("[TB] FAIL order_hold%0d got v=%b ch=%0d want 1/0", i, bus.start_valid, bus.start_ch); end
            tick();
        end
        bus.start_ready = 1;
        got = 0; cyc = 0;
        while (got < 5 && cyc < 20) begin
            if (bus.start_valid) begin
                rec_ch[got] = bus.start_ch; rec_sh[got] = bus.start_shape; rec_op[got] = bus.start_op;
                got++;
            end
            drop = bus.wr_valid && bus.wr_ready;
            tick();
            cyc++;
            if (drop) begin
                bus.wr_valid = 0;
                total++; if (bus.wr_done !== 1'b1 || bus.wr_err !== 1'b0) begin bad++; $display("[TB] FAIL order_rewrite got done=%b err=%b want 1/0", bus.wr_done, bus.wr_err); end
            end
        end
        total++; if (got !== 5) begin bad++; $display("[TB] FAIL order_count got=%0d want=5", got); end
        for (int i = 0; i < got; i++) begin
            total++; if (int'(rec_ch[i]) !== exp_ch[i] || rec_sh[i] !== exp_sh[i] || rec_op[i] !== exp_op[i])
                begin bad++; $display("[TB] FAIL order_job%0d got ch=%0d sh=%b op=%b want ch=%0d sh=%b op=%b", i, rec_ch[i], rec_sh[i], rec_op[i], exp_ch[i], exp_sh[i], exp_op[i]); end
        end
        bus.wr_valid = 0;
        tick();
        total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL order_drain got=%b want=0", bus.start_valid); end
    endtask

    task automatic test_err_sat();
        bus.start_ready = 1;
        for (int i = 0; i < 300; i++) begin
            bus.wr_valid = 1; bus.wr_ch = CH_W'($urandom_range(0, NUM_CH - 1));
            bus.wr_data = $urandom() | 32'h0003_0000;
            tick();
            if (i == 9) begin
                total++; if (bus.err_cnt !== 8'd13) begin bad++; $display("[TB] FAIL sat_mid got=%0d want=13", bus.err_cnt); end
            end
        end
        total++; if (bus.err_cnt !== 8'hFF || bus.wr_err !== 1'b1) begin bad++; $display("[TB] FAIL sat_hold got cnt=%h err=%b want ff/1", bus.err_cnt, bus.wr_err); end
        bus.err_clr = 1;
        tick();
        bus.err_clr = 0;
        total++; if (bus.err_cnt !== 8'h00 || bus.wr_err !== 1'b1) begin bad++; $display("[TB] FAIL sat_clear_wins got cnt=%h err=%b want 00/1", bus.err_cnt, bus.wr_err); end
        tick();
        bus.wr_valid = 0;
        total++; if (bus.err_cnt !== 8'h01) begin bad++; $display("[TB] FAIL sat_restart got=%h want=01", bus.err_cnt); end
    endtask

    task automatic test_random();
        bit hold;
        for (int n = 0; n < 400; n++) begin
            total++; if (bus.start_valid !== m_sv) begin bad++; $display("[TB] FAIL rand_start_valid cyc%0d got=%b want=%b", n, bus.start_valid, m_sv); end
            if (m_sv) begin
                total++; if (bus.start_ch !== m_sch || bus.start_shape !== m_sshape || bus.start_op !== m_sop)
                    begin bad++; $display("[TB] FAIL rand_start_job cyc%0d got %0d/%b/%b want %0d/%b/%b", n, bus.start_ch, bus.start_shape, bus.start_op, m_sch, m_sshape, m_sop); end
            end
            total++; if (bus.wr_done !== m_done || bus.wr_err !== m_err) begin bad++; $display("[TB] FAIL rand_wr_resp cyc%0d got %b/%b want %b/%b", n, bus.wr_done, bus.wr_err, m_done, m_err); end
            total++; if (bus.rd_valid !== m_rv || bus.rd_data !== m_rdata) begin bad++; $display("[TB] FAIL rand_read cyc%0d got %b/%h want %b/%h", n, bus.rd_valid, bus.rd_data, m_rv, m_rdata); end
            total++; if (int'(bus.err_cnt) !== m_cnt) begin bad++; $display("[TB] FAIL rand_err_cnt cyc%0d got=%0d want=%0d", n, bus.err_cnt, m_cnt); end
            hold = bus.wr_valid && m_pend[bus.wr_ch];
            if (!hold) begin
                bus.wr_valid = ($urandom_range(0, 9) < 6);
                bus.wr_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
                bus.wr_data  = rand_data();
            end
            bus.rd_en       = $urandom_range(0, 1) == 1;
            bus.rd_ch       = CH_W'($urandom_range(0, NUM_CH - 1));
            bus.start_ready = ($urandom_range(0, 9) < 7);
            bus.err_clr     = ($urandom_range(0, 29) == 0);
            #1;
            total++; if (bus.wr_ready !== !m_pend[bus.wr_ch]) begin bad++; $display("[TB] FAIL rand_wr_ready cyc%0d got=%b want=%b", n, bus.wr_ready, !m_pend[bus.wr_ch]); end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        bus.start_ready = 1;
        repeat (6) tick();
        bus.start_ready = 0;
        bus.wr_valid = 1; bus.wr_ch = 1; bus.wr_data = 32'h0002_0001;
        tick();
        bus.wr_valid = 0;
        repeat (3) tick();
        total++; if (bus.start_valid !== 1'b1 || bus.start_ch !== 2'd1) begin bad++; $display("[TB] FAIL rstmid_pre got v=%b ch=%0d want 1/1", bus.start_valid, bus.start_ch); end
        #2 rst_n = 0;
        #1;
        total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_abort got=%b want=0", bus.start_valid); end
        total++; if (bus.wr_ready !== 1'b1 || bus.err_cnt !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_state got rdy=%b cnt=%h want 1/00", bus.wr_ready, bus.err_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        bus.start_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.start_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_nostart%0d got=%b want=0", i, bus.start_valid); end
        end
        bus.rd_en = 1; bus.rd_ch = 1;
        tick();
        bus.rd_en = 0;
        total++; if (bus.rd_data !== 32'h0001_0000) begin bad++; $display("[TB] FAIL rstmid_reg got=%h want=00010000", bus.rd_data); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_keep();
        test_basic_write();
        test_reject();
        test_order();
        test_err_sat();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
